// File: rtl/uni_pkg.sv
// ---------------------------------------------------------------------------
// uni_pkg
// Shared definitions for the unified memory interface responder.
//   - Access-size encodings SZ_B/SZ_H/SZ_W/SZ_D (i_req_size values)
//   - Responder FSM state enum (IDLE/BUSY/RESP)
//   - byte_mask():  8-bit lane enable for a size at a byte offset within a dword
//   - align_mask(): low-address bits that must be zero for a naturally aligned access
// ---------------------------------------------------------------------------
package uni_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    // ((1 << (1 << size)) - 1) << off, written as a table so it stays 8 bits wide.
    function automatic logic [7:0] byte_mask(input logic [1:0] size, input logic [2:0] off);
        logic [7:0] lanes;
        case (size)
            SZ_B:    lanes = 8'h01;
            SZ_H:    lanes = 8'h03;
            SZ_W:    lanes = 8'h0F;
            default: lanes = 8'hFF;
        endcase
        return lanes << off;
    endfunction

    // (1 << size) - 1 restricted to the three in-dword address bits.
    function automatic logic [2:0] align_mask(input logic [1:0] size);
        logic [2:0] m;
        case (size)
            SZ_B:    m = 3'b000;
            SZ_H:    m = 3'b001;
            SZ_W:    m = 3'b011;
            default: m = 3'b111;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/uni_mem_array.sv
// ---------------------------------------------------------------------------
// uni_mem_array
// DEPTH x 64-bit single-port storage with per-byte write enables.
// Synchronous write, combinational read (the responder registers the read).
//   i_clk    clock
//   i_we     write strobe for this cycle
//   i_be     byte-lane enables, bit n covers i_wdata[8n+7:8n]
//   i_idx    doubleword index (shared by read and write)
//   i_wdata  write data, already shifted into its lanes
//   o_rdata  current contents of entry i_idx
// Contents are never reset.
// ---------------------------------------------------------------------------
module uni_mem_array #(
    parameter int DEPTH = 4096,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_we,
    input  logic [7:0]       i_be,
    input  logic [IDX_W-1:0] i_idx,
    input  logic [63:0]      i_wdata,
    output logic [63:0]      o_rdata
);

    // One 8-bit-wide array per byte lane keeps byte enables trivially mappable.
    for (genvar gi = 0; gi < 8; gi++) begin : g_lane
        logic [7:0] lane_mem [DEPTH];

        always_ff @(posedge i_clk) begin
            if (i_we && i_be[gi]) begin
                lane_mem[i_idx] <= i_wdata[8*gi +: 8];
            end
        end

        assign o_rdata[8*gi +: 8] = lane_mem[i_idx];
    end

endmodule

// File: rtl/uni_mem_slave.sv
// ---------------------------------------------------------------------------
// uni_mem_slave
// Responder for one unified-memory master port. Takes one request at a time,
// waits LATENCY cycles, performs the access on the internal array and holds
// the response until the master takes it.
//   i_clk / i_rst_n          clock, asynchronous active-low reset
//   i_req_valid/o_req_ready  request handshake
//   i_req_addr/wen/size/wdata request fields (wdata right-aligned)
//   o_resp_valid/i_resp_ready response handshake
//   o_resp_rdata             aligned doubleword read (0 for writes/errors)
//   o_resp_err               out-of-range or misaligned access
// ---------------------------------------------------------------------------
module uni_mem_slave
    import uni_pkg::*;
#(
    parameter int                ADDR_W    = 64,
    parameter int                DATA_W    = 64,
    parameter int                MEM_DEPTH = 4096,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 64'h8000_0000,
    parameter int                LATENCY   = 2
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic              i_req_wen,
    input  logic [1:0]        i_req_size,
    input  logic [DATA_W-1:0] i_req_wdata,
    output logic              o_resp_valid,
    input  logic              i_resp_ready,
    output logic [DATA_W-1:0] o_resp_rdata,
    output logic              o_resp_err
);

    localparam int         IDX_W  = $clog2(MEM_DEPTH);
    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    state_e              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                ready_q, ready_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                wen_q, wen_d;
    logic [1:0]          size_q, size_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;

    logic                accept;
    logic                commit;
    logic [ADDR_W-1:0]   acc_addr;
    logic [ADDR_W-1:0]   acc_off;
    logic                acc_wen;
    logic [1:0]          acc_size;
    logic [DATA_W-1:0]   acc_wdata;
    logic                acc_err;
    logic [DATA_W-1:0]   mem_rdata;

    assign accept = (state_q == IDLE) && ready_q && i_req_valid;

    // With LATENCY==1 the access happens on the accepting edge, so it must
    // use the live request fields; otherwise the latched copy is used.
    always_comb begin
        if (state_q == IDLE) begin
            acc_addr  = i_req_addr;
            acc_wen   = i_req_wen;
            acc_size  = i_req_size;
            acc_wdata = i_req_wdata;
        end else begin
            acc_addr  = addr_q;
            acc_wen   = wen_q;
            acc_size  = size_q;
            acc_wdata = wdata_q;
        end
    end

    assign acc_off = acc_addr - BASE_ADDR;
    assign acc_err = (acc_addr < BASE_ADDR)
                  || ((acc_off >> 3) >= ADDR_W'(MEM_DEPTH))
                  || ((acc_addr[2:0] & align_mask(acc_size)) != 3'b000);

    uni_mem_array #(
        .DEPTH (MEM_DEPTH),
        .IDX_W (IDX_W)
    ) u_array (
        .i_clk   (i_clk),
        .i_we    (commit && acc_wen && !acc_err),
        .i_be    (byte_mask(acc_size, acc_addr[2:0])),
        .i_idx   (acc_off[IDX_W+2:3]),
        .i_wdata (acc_wdata << {acc_addr[2:0], 3'b000}),
        .o_rdata (mem_rdata)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ready_d = ready_q;
        addr_d  = addr_q;
        wen_d   = wen_q;
        size_d  = size_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        commit  = 1'b0;
        case (state_q)
            IDLE: begin
                // ready is low for the single idle cycle after a response.
                ready_d = 1'b1;
                if (accept) begin
                    ready_d = 1'b0;
                    addr_d  = i_req_addr;
                    wen_d   = i_req_wen;
                    size_d  = i_req_size;
                    wdata_d = i_req_wdata;
                    cnt_d   = LAT_M1;
                    if (LATENCY == 1) begin
                        commit  = 1'b1;
                        state_d = RESP;
                    end else begin
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                // Access fires on the edge where the counter reaches zero.
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    commit  = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (i_resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (commit) begin
            err_d   = acc_err;
            rdata_d = (acc_err || acc_wen) ? '0 : mem_rdata;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            ready_q <= 1'b1;
            addr_q  <= '0;
            wen_q   <= 1'b0;
            size_q  <= SZ_B;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            addr_q  <= addr_d;
            wen_q   <= wen_d;
            size_q  <= size_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign o_req_ready  = ready_q && i_rst_n;
    assign o_resp_valid = (state_q == RESP);
    assign o_resp_rdata = rdata_q;
    assign o_resp_err   = err_q;

    a_wen_known: assert property (@(posedge i_clk) disable iff (!i_rst_n)
                                  i_req_valid |-> !$isunknown(i_req_wen));

endmodule

// File: doc/uni_mem_slave.md
Name: uni_mem_slave

Overview:
- Responder (slave) end of the unified memory interface driven by the core's IFU and LSU master ports.
- Accepts one request at a time, models a fixed access latency, and services reads and writes against an internal doubleword-organised SRAM array.
- Returns a response through a valid/ready handshake.
- Used as the simulation and FPGA memory behind each core master port; one instance per port.

Parameters:
- ADDR_W, 64, request address width
- DATA_W, 64, data width; fixed at 64, one doubleword per array entry
- MEM_DEPTH, 4096, number of doubleword entries
- BASE_ADDR, 64'h8000_0000, byte address of entry 0
- LATENCY, 2, cycles from request acceptance to response valid; legal range 1..15

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_req_valid  in  1  master request valid
- o_req_ready  out  1  slave can accept a request
- i_req_addr  in  ADDR_W  byte address
- i_req_wen  in  1  1 = write, 0 = read
- i_req_size  in  2  access size: 0 = byte, 1 = half, 2 = word, 3 = dword
- i_req_wdata  in  DATA_W  write data, right-aligned (bits [8<<size-1:0] valid)
- o_resp_valid  out  1  response valid
- i_resp_ready  in  1  master accepts the response
- o_resp_rdata  out  DATA_W  read data, full aligned doubleword containing the address
- o_resp_err  out  1  access was out of range or misaligned

Behaviour:
- Reset (async assert, sync release) puts the FSM in IDLE.
  - Reset values: o_req_ready = 1 after reset release (0 while i_rst_n low), o_resp_valid = 0, o_resp_rdata = 0, o_resp_err = 0, latency counter = 0.
  - Array contents are not reset.
- FSM states IDLE, BUSY, RESP:
  - IDLE: o_req_ready = 1. When i_req_valid & o_req_ready, latch addr, wen, size and wdata, load the counter with LATENCY-1, and go to BUSY. If LATENCY==1, go directly to RESP.
  - BUSY: o_req_ready = 0. The counter decrements each cycle; at 0, perform the access and go to RESP.
  - RESP: o_resp_valid = 1. rdata and err are held stable until i_resp_ready. On the handshake, go to IDLE; o_req_ready rises the next cycle. No request is accepted in the same cycle as the response handshake.
- Latency: with i_resp_ready tied high, o_resp_valid asserts exactly LATENCY cycles after the accepting edge.
- Index = (addr - BASE_ADDR) >> 3.
- Error conditions; any of these sets err, and the array is not written:
  - addr < BASE_ADDR;
  - index >= MEM_DEPTH;
  - addr not aligned to its size (addr & ((1<<size)-1) != 0).
- Error read data: rdata = 0 on error.
- Write, no error:
  - Byte mask = ((1<<(1<<size))-1) << addr[2:0].
  - Data is shifted left by 8*addr[2:0].
  - Only masked bytes of the entry change.
  - rdata for a write response = 0.
- Read, no error: rdata = entry[index] as it stood before the response cycle. Sub-word extraction and sign extension are the master's job.
- Back-to-back: a write followed by a read to the same entry returns the written data. The write commits before RESP, so there is no hazard.
- Request inputs are ignored outside IDLE, and i_req_valid may drop without effect. Masters hold the request until ready per protocol.
- i_resp_ready asserted while o_resp_valid = 0 has no effect.
- Reset mid-operation (BUSY or RESP):
  - The transaction is dropped and no response is produced.
  - A write whose commit cycle has not occurred is not performed.
- An X on i_req_wen while i_req_valid = 1 triggers an assertion.

Decomposition:
- Package uni_pkg holds:
  - size encoding constants SZ_B, SZ_H, SZ_W, SZ_D;
  - state enum IDLE/BUSY/RESP;
  - the function computing the 8-bit byte mask from size and addr[2:0].
- Sub-module uni_mem_array: MEM_DEPTH x 64 single-port array with byte-write-enable. Synchronous write, combinational read, registered into o_resp_rdata by the FSM.

Test Plan:
- LATENCY=2, write dword 0x1122334455667788 to 0x80000010, then read 0x80000010 -> write response err=0; read rdata=0x1122334455667788; each o_resp_valid exactly 2 cycles after acceptance.
- After the above, write byte 0xAB to 0x80000013 (size 0), then read the dword -> rdata=0x11223344AB667788.
- Read 0x80000010 with i_resp_ready held low 5 cycles -> o_resp_valid, rdata and err stable throughout; o_req_ready=0; a new i_req_valid is ignored; after the handshake, o_req_ready=1 the next cycle.
- Read 0x7FFFFFF8, read BASE_ADDR+8*MEM_DEPTH, and write half to 0x80000011 -> each gives err=1, rdata=0; the entry at 0x80000010 is unchanged.
- Write accepted, i_rst_n pulsed low during BUSY -> no response; outputs at reset values; a subsequent read shows the old data.
- LATENCY=1 back-to-back reads of 0x80000000 and 0x80000008 with ready high -> one response per 3-cycle period (accept, resp, idle); data correct.
